// File: rtl/mii_tx_framer.sv
// mii_tx_framer: turns a byte stream into an MII transmit nibble stream.
// Adds preamble/SFD, zero-pads short frames, appends the Ethernet FCS and
// holds the line idle for the inter-frame gap. A source that stalls
// mid-frame gets the frame aborted with TX_ER, and the rest of its bytes
// are discarded.
//
// Ports
//   clk, rst           MII transmit clock; asynchronous active-low reset.
//                      rst is expected to be released synchronously to clk.
//   s_tdata/s_tvalid   byte stream in, destination MAC first, no FCS
//   s_tready           byte taken on a cycle with s_tvalid & s_tready
//   s_tlast/s_tuser    last byte of frame / byte is errored
//   phy_txd            registered MII transmit nibble
//   phy_tx_en          registered MII transmit enable
//   phy_tx_er          registered MII transmit error
//   busy               high whenever the FSM is not in IDLE
//   frame_done         one-cycle pulse on the last FCS nibble
//   underflow          one-cycle pulse when the source starves mid-frame
//
// state    | meaning
// IDLE     | line quiet, waiting for s_tvalid
// PREAMBLE | fifteen 0x5 nibbles then 0xD; first byte taken on the 0xD cycle
// DATA     | byte being sent, low nibble then high nibble
// PAD      | zero byte being sent to reach the minimum frame length
// FCS      | eight nibbles of inverted CRC, least significant first
// DRAIN    | frame aborted; swallowing bytes through s_tlast
// IFG      | inter-frame gap, phy_tx_en low

module mii_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_CYCLES      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic [3:0] phy_txd,
  output logic       phy_tx_en,
  output logic       phy_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);

  localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
  localparam logic [15:0] IFG_LOAD  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, DRAIN, IFG} state_t;

  state_t      state;
  logic [3:0]  nib_cnt;
  logic        hi_nib;
  logic [3:0]  byte_hi;
  logic        byte_last;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [15:0] ifg_cnt;

  logic        in_payload;
  logic        start;
  logic        take;
  logic        starve;
  logic        payload_end;
  logic        enter_gap;
  logic        pad_more;
  logic [10:0] byte_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ({1'b0, r[31:1]} ^ 32'hEDB8_8320) : {1'b0, r[31:1]};
    end
    return r;
  endfunction

  // Each event below is exclusive of the others, so the register block can
  // treat them as a priority chain and fall back to per-state nibble stepping.
  always_comb begin
    in_payload  = (state == PREAMBLE) || (state == DATA);
    start       = s_tvalid && ((state == IDLE) || ((state == IFG) && (ifg_cnt == 16'd0)));
    take        = in_payload && s_tready && s_tvalid;
    starve      = in_payload && s_tready && !s_tvalid;
    payload_end = hi_nib && (((state == DATA) && byte_last) || (state == PAD));
    enter_gap   = ((state == FCS) && (nib_cnt == 4'd7)) ||
                  ((state == DRAIN) && s_tready && s_tvalid && s_tlast);
    pad_more    = byte_cnt < MIN_BYTES;
    byte_next   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      nib_cnt    <= 4'd0;
      hi_nib     <= 1'b0;
      byte_hi    <= 4'd0;
      byte_last  <= 1'b0;
      byte_cnt   <= 11'd0;
      crc        <= CRC_INIT;
      ifg_cnt    <= 16'd0;
      s_tready   <= 1'b0;
      phy_txd    <= 4'd0;
      phy_tx_en  <= 1'b0;
      phy_tx_er  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      if (start) begin
        state     <= PREAMBLE;
        busy      <= 1'b1;
        nib_cnt   <= 4'd0;
        byte_cnt  <= 11'd0;
        crc       <= CRC_INIT;
        phy_txd   <= 4'h5;
        phy_tx_en <= 1'b1;
        phy_tx_er <= 1'b0;
        s_tready  <= 1'b0;
      end else if (take) begin
        state     <= DATA;
        hi_nib    <= 1'b0;
        byte_hi   <= s_tdata[7:4];
        byte_last <= s_tlast;
        byte_cnt  <= byte_next;
        crc       <= crc_byte(crc, s_tdata);
        phy_txd   <= s_tdata[3:0];
        phy_tx_er <= s_tuser;
        s_tready  <= 1'b0;
      end else if (starve) begin
        // One error nibble while tx_en is still high, then go quiet.
        state     <= DRAIN;
        phy_txd   <= 4'd0;
        phy_tx_er <= 1'b1;
        underflow <= 1'b1;
        s_tready  <= 1'b0;
      end else if (payload_end) begin
        phy_tx_er <= 1'b0;
        if (pad_more) begin
          state    <= PAD;
          hi_nib   <= 1'b0;
          byte_cnt <= byte_next;
          crc      <= crc_byte(crc, 8'h00);
          phy_txd  <= 4'd0;
        end else begin
          state   <= FCS;
          nib_cnt <= 4'd0;
          phy_txd <= ~crc[3:0];
          crc     <= {4'h0, crc[31:4]};
        end
      end else if (enter_gap) begin
        phy_txd   <= 4'd0;
        phy_tx_en <= 1'b0;
        phy_tx_er <= 1'b0;
        s_tready  <= 1'b0;
        if (IFG_CYCLES > 0) begin
          state   <= IFG;
          ifg_cnt <= IFG_LOAD;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          PREAMBLE: begin
            nib_cnt  <= nib_cnt + 4'd1;
            phy_txd  <= (nib_cnt == 4'd14) ? 4'hD : 4'h5;
            s_tready <= (nib_cnt == 4'd14);
          end
          // Only the low-nibble cycle reaches here; tx_er keeps the byte's flag.
          DATA, PAD: begin
            hi_nib   <= 1'b1;
            phy_txd  <= (state == DATA) ? byte_hi : 4'd0;
            s_tready <= (state == DATA) && !byte_last;
          end
          FCS: begin
            nib_cnt    <= nib_cnt + 4'd1;
            phy_txd    <= ~crc[3:0];
            crc        <= {4'h0, crc[31:4]};
            frame_done <= (nib_cnt == 4'd6);
          end
          DRAIN: begin
            phy_txd   <= 4'd0;
            phy_tx_en <= 1'b0;
            phy_tx_er <= 1'b0;
            s_tready  <= 1'b1;
          end
          IFG: begin
            if (ifg_cnt == 16'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              ifg_cnt <= ifg_cnt - 16'd1;
            end
          end
          IDLE: begin
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
module tb_mii_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, s_tready;
  logic [3:0] phy_txd;
  logic       phy_tx_en, phy_tx_er, busy, frame_done, underflow;

  logic [7:0] b_tdata;
  logic       b_tvalid, b_tlast, b_tuser, b_tready;
  logic [3:0] b_txd;
  logic       b_tx_en, b_tx_er, b_busy, b_frame_done, b_underflow;

  mii_tx_framer dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .phy_txd(phy_txd), .phy_tx_en(phy_tx_en),
    .phy_tx_er(phy_tx_er), .busy(busy), .frame_done(frame_done), .underflow(underflow)
  );

  mii_tx_framer #(.MIN_FRAME_BYTES(0), .IFG_CYCLES(24)) dut_np (
    .clk(clk), .rst(rst), .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_tready),
    .s_tlast(b_tlast), .s_tuser(b_tuser), .phy_txd(b_txd), .phy_tx_en(b_tx_en),
    .phy_tx_er(b_tx_er), .busy(b_busy), .frame_done(b_frame_done), .underflow(b_underflow)
  );

  typedef struct packed {
    logic [3:0] txd;
    logic       er;
    logic       fd;
    logic       uf;
  } nib_t;

  nib_t       exp_q[$];
  int         len_q[$];
  int         gap_q[$];
  logic [4:0] exp_b[$];
  int         len_b[$];

  int total = 0;
  int bad   = 0;
  bit ignore = 1'b0;
  int run = 0, low = 0, run_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic nib_t mk(input logic [3:0] t, input logic er, input logic fd, input logic uf);
    nib_t n;
    n.txd = t; n.er = er; n.fd = fd; n.uf = uf;
    return n;
  endfunction

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed + 37 * i);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_pre();
    for (int i = 0; i < 15; i++) exp_q.push_back(mk(4'h5, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'hD, 1'b0, 1'b0, 1'b0));
  endtask

  // Expected nibbles of a complete frame on the default-parameter DUT.
  task automatic push_frame(input int n, input int seed, input int uidx, input int gap);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    c = 32'hFFFF_FFFF;
    push_pre();
    for (int i = 0; i < n; i++) begin
      b = pat(seed, i);
      exp_q.push_back(mk(b[3:0], i == uidx, 1'b0, 1'b0));
      exp_q.push_back(mk(b[7:4], i == uidx, 1'b0, 1'b0));
      c = crc_upd(c, b);
    end
    tot = (n < 60) ? 60 : n;
    for (int i = n; i < tot; i++) begin
      exp_q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0));
      c = crc_upd(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(c[4*k +: 4], 1'b0, k == 7, 1'b0));
    len_q.push_back(16 + 2 * tot + 8);
    gap_q.push_back(gap);
  endtask

  // Frame cut short by a starved source after n good bytes.
  task automatic push_uf(input int n, input int seed);
    logic [7:0] b;
    push_pre();
    for (int i = 0; i < n; i++) begin
      b = pat(seed, i);
      exp_q.push_back(mk(b[3:0], 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(b[7:4], 1'b0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(4'h0, 1'b1, 1'b0, 1'b1));
    len_q.push_back(16 + 2 * n + 1);
    gap_q.push_back(-1);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic put_byte(input bit which, input logic [7:0] d, input logic l, input logic u);
    int n;
    if (!which) begin
      s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    end else begin
      b_tdata = d; b_tlast = l; b_tuser = u; b_tvalid = 1'b1;
    end
    n = 0;
    while (((which ? b_tready : s_tready) == 1'b0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      total++; bad++;
      $display("FAIL handshake_timeout: got no s_tready, want s_tready within 4000 cycles");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send(input int n, input int seed, input int uidx, input bit hold);
    for (int i = 0; i < n; i++) put_byte(1'b0, pat(seed, i), i == n - 1, i == uidx);
    if (!hold) begin
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d nibbles outstanding, want 0", exp_q.size() + exp_b.size());
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor for the padded DUT: every tx_en cycle consumes one expected nibble.
  always @(negedge clk) begin
    nib_t e;
    int   g;
    if (!rst || ignore) begin
      run = 0;
      low = 0;
    end else if (phy_tx_en) begin
      if (run == 0 && gap_q.size() != 0) begin
        g = gap_q.pop_front();
        if (g >= 0) chk("ifg_gap", low, g);
      end
      run++;
      low = 0;
      if (exp_q.size() == 0) begin
        chk("extra_nibble", {phy_txd, phy_tx_er}, 5'h1F);
      end else begin
        e = exp_q.pop_front();
        chk("txd", phy_txd, e.txd);
        chk("tx_er", phy_tx_er, e.er);
        chk("frame_done", frame_done, e.fd);
        chk("underflow", underflow, e.uf);
      end
    end else begin
      if (run != 0) begin
        if (len_q.size() != 0) chk("tx_en_len", run, len_q.pop_front());
        run = 0;
      end
      low++;
      chk("idle_outputs", {phy_txd, phy_tx_er, frame_done, underflow}, 0);
    end
  end

  // Monitor for the unpadded DUT.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst) begin
      run_b = 0;
    end else if (b_tx_en) begin
      run_b++;
      if (exp_b.size() == 0) begin
        chk("np_extra_nibble", b_txd, 5'h1F);
      end else begin
        e = exp_b.pop_front();
        chk("np_txd", b_txd, e[4:1]);
        chk("np_frame_done", b_frame_done, e[0]);
        chk("np_tx_er", b_tx_er, 0);
      end
    end else if (run_b != 0) begin
      if (len_b.size() != 0) chk("np_tx_en_len", run_b, len_b.pop_front());
      run_b = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string      msg;
    logic [3:0] fcs_n [8];
    logic [7:0] ch;
    int         n;

    rst = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    b_tdata = 8'h00; b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {phy_txd, phy_tx_en, phy_tx_er, s_tready, busy, frame_done, underflow}, 0);
    chk("rst_np_outputs", {b_txd, b_tx_en, b_tx_er, b_tready, b_busy, b_frame_done, b_underflow}, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // "123456789" without padding: CRC 0xCBF43926.
    msg = "123456789";
    fcs_n = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    for (int i = 0; i < 15; i++) exp_b.push_back({4'h5, 1'b0});
    exp_b.push_back({4'hD, 1'b0});
    for (int i = 0; i < 9; i++) begin
      ch = msg[i];
      exp_b.push_back({ch[3:0], 1'b0});
      exp_b.push_back({ch[7:4], 1'b0});
    end
    for (int k = 0; k < 8; k++) exp_b.push_back({fcs_n[k], k == 7});
    len_b.push_back(42);
    for (int i = 0; i < 9; i++) put_byte(1'b1, msg[i], i == 8, 1'b0);
    b_tvalid = 1'b0; b_tlast = 1'b0;
    wait_idle();

    // 14-byte frame, padded to 60; first nibble one cycle after s_tvalid seen.
    push_frame(14, 16, -1, -1);
    chk("idle_tready", {s_tready, busy}, 0);
    s_tdata = pat(16, 0); s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
    @(negedge clk);
    chk("first_nibble_latency", {busy, phy_tx_en, phy_txd}, 6'h35);
    send(14, 16, -1, 1'b0);
    wait_idle();

    // Errored byte 3 in a 20-byte frame.
    push_frame(20, 40, 3, -1);
    send(20, 40, 3, 1'b0);
    wait_idle();

    // Back-to-back 64-byte frames with s_tvalid held: 24 idle clocks between.
    push_frame(64, 7, -1, -1);
    push_frame(64, 99, -1, 24);
    send(64, 7, -1, 1'b1);
    send(64, 99, -1, 1'b0);
    wait_idle();

    // Source starves after 5 of 20 bytes; remaining bytes are drained.
    push_uf(5, 3);
    for (int i = 0; i < 5; i++) put_byte(1'b0, pat(3, i), 1'b0, 1'b0);
    s_tvalid = 1'b0;
    n = 0;
    while (!underflow && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("underflow_pulse", {underflow, phy_tx_en, phy_tx_er}, 3'b111);
    for (int i = 5; i < 20; i++) put_byte(1'b0, pat(3, i), i == 19, 1'b0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("drain_busy", busy, 1);
    push_frame(14, 50, -1, -1);
    send(14, 50, -1, 1'b0);
    wait_idle();

    // Reset in the middle of DATA, then a clean frame.
    ignore = 1'b1;
    for (int i = 0; i < 3; i++) put_byte(1'b0, pat(5, i), 1'b0, 1'b0);
    chk("mid_data_tx_en", phy_tx_en, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", {phy_txd, phy_tx_en, phy_tx_er, s_tready, busy, frame_done, underflow}, 0);
    s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    ignore = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {phy_tx_en, busy}, 0);
    push_frame(14, 77, -1, -1);
    send(14, 77, -1, 1'b0);
    wait_idle();

    chk("queues_empty", exp_q.size() + len_q.size() + gap_q.size() + exp_b.size() + len_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
